wshb_arbiter: RTL and testbench
===============================

// Module: wshb_arbiter
// PURPOSE
//  Two-master Wishbone B4 arbiter sharing the single SDRAM slave port.
//  Master 0 is the mire pattern writer; master 1 is the VGA frame reader.
//  VGA has priority. Preemption happens only at transfer/burst boundaries,
//  and a bounded-hold guard prevents the writer from starving.
//  A one-cycle dead slot (s_cyc=0) separates back-to-back owners.
// PARAMETERS
//  DW        16  data width (dat_ms/dat_sm)
//  AW        32  address width
//  MAX_HOLD  64  max acks VGA may take while mire waits; >=1
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      asynchronous, active-low reset
//  m{0,1}_cyc   in   1      master cycle request
//  m{0,1}_stb   in   1      master strobe
//  m{0,1}_we    in   1      master write enable (1=write)
//  m{0,1}_adr   in   AW     master address
//  m{0,1}_dat   in   DW     master write data
//  m{0,1}_sel   in   DW/8   master byte select
//  m{0,1}_cti   in   3      master cycle type (000 classic, 010 incr, 111 end)
//  m{0,1}_bte   in   2      master burst type
//  m{0,1}_ack   out  1      ack to master; only the owner ever sees it
//  m{0,1}_rdat  out  DW     read data, both driven from s_rdat
//  s_cyc/s_stb/s_we  out 1  slave controls, muxed from the owner
//  s_adr/s_dat/s_sel/s_cti/s_bte out AW/DW/DW/8/3/2  slave fields, muxed from the owner
//  s_ack        in   1      slave acknowledge
//  s_rdat       in   DW     slave read data
//  gnt          out  2      one-hot owner: 01=m0, 10=m1, 00=none
// BEHAVIOUR
//  - States (shared enum): IDLE, GNT0, GNT1, SWITCH. Registers: state, sw_tgt (1b), hold_cnt.
//  - Reset (rst=0, async): state=IDLE, sw_tgt=0, hold_cnt=0. Every out is 0:
//    s_cyc, s_stb, m*_ack, gnt. Masters must restart any interrupted cycle.
//  - Outputs are combinational from the registered state; slave path has zero added latency.
//    IDLE/SWITCH: s_cyc=s_stb=0, both acks 0, s_* fields 0.
//    GNTx: s_* = mx_*, mx_ack = s_ack, the other ack = 0.
//  - Boundary: s_ack & (owner cti==000 | owner cti==111).
//  - IDLE: m1_cyc -> GNT1; else m0_cyc -> GNT0. Simultaneous requests: m1 wins.
//  - GNT0: !m0_cyc -> GNT1 if m1_cyc else IDLE (no dead cycle).
//    boundary & m1_cyc -> SWITCH with sw_tgt=1.
//  - GNT1: !m1_cyc -> GNT0 if m0_cyc else IDLE.
//    boundary & m0_cyc & hold_cnt>=MAX_HOLD-1 -> SWITCH with sw_tgt=0.
//  - SWITCH (exactly 1 cycle):
//    -> GNT(sw_tgt) if its cyc is still high; else the other GNT if its cyc is high; else IDLE.
//  - hold_cnt: width $clog2(MAX_HOLD+1). Increments on s_ack in GNT1 while m0_cyc=1.
//    Saturates at MAX_HOLD. Clears on any entry to GNT0 or IDLE.
//  - The preempted master keeps cyc/stb high and simply sees no ack until regranted.
//    Its burst resumes from its current address; the arbiter does not replay.
//  - s_ack arriving in IDLE/SWITCH is ignored (protocol error, not forwarded).
// STRUCTURE
//  - Package wshb_arb_pkg: arb_state_t enum, CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111.
//  - Single module. The request/grant FSM and hold counter are too small to split.
//    The mux is one always_comb keyed on state.
// TESTING
//  1 m0 only, 8-beat burst (cti 010 x7, then 111), slave acks every cycle
//    -> gnt=01, 8 m0_acks, m1_ack never 1, IDLE one cycle after m0_cyc falls.
//  2 m0_cyc and m1_cyc rise in the same cycle from IDLE
//    -> gnt=10 next cycle, s_adr=m1_adr.
//  3 m0 mid-burst (beat 3 of 8), m1_cyc rises
//    -> m0 keeps the bus until its cti=111 ack; one cycle s_cyc=0; then gnt=10.
//  4 MAX_HOLD=4, m1 back-to-back classic reads, m0 requesting
//    -> after the 4th m1 ack: SWITCH, then gnt=01. After m0's next boundary: gnt=10.
//  5 rst driven low mid-burst between clock edges
//    -> s_cyc, s_stb, m0_ack, m1_ack, gnt all 0 immediately. After release with no cyc: stays IDLE.
//  6 Owner m1 drops cyc while m0_cyc=1
//    -> gnt=01 on the next cycle with no SWITCH slot; hold_cnt reads 0.

Source files
------------

// File: rtl/wshb_arb_pkg.sv
// Shared types and Wishbone cycle-type codes for the two-master SDRAM arbiter.
package wshb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT0   = 2'd1,
        GNT1   = 2'd2,
        SWITCH = 2'd3
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // A transfer or burst is over when its final beat is acknowledged.
    function automatic logic is_boundary(input logic ack, input logic [2:0] cti);
        return ack && ((cti == CTI_CLASSIC) || (cti == CTI_END));
    endfunction

endpackage

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone B4 arbiter: VGA reader (m1) has priority, the mire writer (m0) is
// protected from starvation by a bounded hold count. Owners change only at burst boundaries.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 32,
    parameter int MAX_HOLD = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m0_cyc,
    input  logic                          m0_stb,
    input  logic                          m0_we,
    input  logic [AW-1:0]                 m0_adr,
    input  logic [DW-1:0]                 m0_dat,
    input  logic [DW/8-1:0]               m0_sel,
    input  logic [2:0]                    m0_cti,
    input  logic [1:0]                    m0_bte,
    output logic                          m0_ack,
    output logic [DW-1:0]                 m0_rdat,
    input  logic                          m1_cyc,
    input  logic                          m1_stb,
    input  logic                          m1_we,
    input  logic [AW-1:0]                 m1_adr,
    input  logic [DW-1:0]                 m1_dat,
    input  logic [DW/8-1:0]               m1_sel,
    input  logic [2:0]                    m1_cti,
    input  logic [1:0]                    m1_bte,
    output logic                          m1_ack,
    output logic [DW-1:0]                 m1_rdat,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [AW-1:0]                 s_adr,
    output logic [DW-1:0]                 s_dat,
    output logic [DW/8-1:0]               s_sel,
    output logic [2:0]                    s_cti,
    output logic [1:0]                    s_bte,
    input  logic                          s_ack,
    input  logic [DW-1:0]                 s_rdat,
    output logic [1:0]                    gnt,
    output logic [1:0]                    dbg_state,
    output logic [$clog2(MAX_HOLD+1)-1:0] dbg_hold
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    arb_state_t    state_q, state_d;
    logic          sw_tgt_q, sw_tgt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          bnd0, bnd1;

    assign bnd0 = is_boundary(s_ack, m0_cti);
    assign bnd1 = is_boundary(s_ack, m1_cti);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sw_tgt_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            sw_tgt_q <= sw_tgt_d;
            hold_q   <= hold_d;
        end
    end

    // A dropped cyc hands over immediately; preemption goes through the SWITCH dead slot.
    always_comb begin
        state_d  = state_q;
        sw_tgt_d = sw_tgt_q;
        case (state_q)
            IDLE: begin
                if (m1_cyc)      state_d = GNT1;
                else if (m0_cyc) state_d = GNT0;
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_d = m1_cyc ? GNT1 : IDLE;
                end else if (bnd0 && m1_cyc) begin
                    state_d  = SWITCH;
                    sw_tgt_d = 1'b1;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_d = m0_cyc ? GNT0 : IDLE;
                end else if (bnd1 && m0_cyc && (hold_q >= HOLD_LIM)) begin
                    state_d  = SWITCH;
                    sw_tgt_d = 1'b0;
                end
            end
            SWITCH: begin
                if (sw_tgt_q ? m1_cyc : m0_cyc)      state_d = sw_tgt_q ? GNT1 : GNT0;
                else if (sw_tgt_q ? m0_cyc : m1_cyc) state_d = sw_tgt_q ? GNT0 : GNT1;
                else                                 state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts VGA acks taken while the writer waits; cleared whenever the writer gets in or the bus idles.
    always_comb begin
        hold_d = hold_q;
        if ((state_q == GNT1) && s_ack && m0_cyc && (hold_q != HOLD_SAT)) begin
            hold_d = hold_q + HW'(1);
        end
        if ((state_d == GNT0) || (state_d == IDLE)) begin
            hold_d = '0;
        end
    end

    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_adr  = '0;
        s_dat  = '0;
        s_sel  = '0;
        s_cti  = '0;
        s_bte  = '0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        gnt    = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc  = m0_cyc;
                s_stb  = m0_stb;
                s_we   = m0_we;
                s_adr  = m0_adr;
                s_dat  = m0_dat;
                s_sel  = m0_sel;
                s_cti  = m0_cti;
                s_bte  = m0_bte;
                m0_ack = s_ack;
                gnt    = 2'b01;
            end
            GNT1: begin
                s_cyc  = m1_cyc;
                s_stb  = m1_stb;
                s_we   = m1_we;
                s_adr  = m1_adr;
                s_dat  = m1_dat;
                s_sel  = m1_sel;
                s_cti  = m1_cti;
                s_bte  = m1_bte;
                m1_ack = s_ack;
                gnt    = 2'b10;
            end
            default: ;
        endcase
    end

    assign m0_rdat   = s_rdat;
    assign m1_rdat   = s_rdat;
    assign dbg_state = state_q;
    assign dbg_hold  = hold_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: table vectors, directed multi-cycle sequences and a random run
// checked against an owner/gap/hold model of the arbitration rules.
module tb_wshb_arbiter;

    localparam int DW       = 16;
    localparam int AW       = 32;
    localparam int MAX_HOLD = 4;
    localparam int HW       = $clog2(MAX_HOLD + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            m_cyc [2];
    logic            m_stb [2];
    logic            m_we  [2];
    logic [AW-1:0]   m_adr [2];
    logic [DW-1:0]   m_dat [2];
    logic [DW/8-1:0] m_sel [2];
    logic [2:0]      m_cti [2];
    logic [1:0]      m_bte [2];
    logic            m0_ack, m1_ack;
    logic [DW-1:0]   m0_rdat, m1_rdat;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat;
    logic [DW/8-1:0] s_sel;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;
    logic            s_ack;
    logic [DW-1:0]   s_rdat;
    logic [1:0]      gnt, dbg_state;
    logic [HW-1:0]   dbg_hold;

    int checks = 0;
    int errors = 0;

    // Model: owner (-1 none), dead-slot flag with its intended target, hold count.
    int mo_own  = -1;
    bit mo_gap  = 1'b0;
    int mo_tgt  = 0;
    int mo_hold = 0;

    typedef struct {
        logic          c0, c1;
        logic [2:0]    t0, t1;
        logic          ack;
        logic [1:0]    e_gnt;
        logic          e_a0, e_a1;
        logic [HW-1:0] e_hold;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    wshb_arbiter #(.DW(DW), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
        .m0_dat(m_dat[0]), .m0_sel(m_sel[0]), .m0_cti(m_cti[0]), .m0_bte(m_bte[0]),
        .m0_ack(m0_ack), .m0_rdat(m0_rdat),
        .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
        .m1_dat(m_dat[1]), .m1_sel(m_sel[1]), .m1_cti(m_cti[1]), .m1_bte(m_bte[1]),
        .m1_ack(m1_ack), .m1_rdat(m1_rdat),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat(s_dat),
        .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte), .s_ack(s_ack), .s_rdat(s_rdat),
        .gnt(gnt), .dbg_state(dbg_state), .dbg_hold(dbg_hold)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic c0, input logic c1, input logic [2:0] t0,
                          input logic [2:0] t1, input logic ack);
        m_cyc[0] = c0;
        m_stb[0] = c0;
        m_cti[0] = t0;
        m_cyc[1] = c1;
        m_stb[1] = c1;
        m_cti[1] = t1;
        s_ack    = ack;
    endtask

    task automatic chk_fields(input string nm, input int own);
        int k;
        k = (own < 0) ? 0 : own;
        chk({nm, ".s_cyc"}, s_cyc, (own < 0) ? 1'b0 : m_cyc[k]);
        chk({nm, ".s_stb"}, s_stb, (own < 0) ? 1'b0 : m_stb[k]);
        chk({nm, ".s_we"},  s_we,  (own < 0) ? 1'b0 : m_we[k]);
        chk({nm, ".s_adr"}, s_adr, (own < 0) ? '0 : m_adr[k]);
        chk({nm, ".s_dat"}, s_dat, (own < 0) ? '0 : m_dat[k]);
        chk({nm, ".s_sel"}, s_sel, (own < 0) ? '0 : m_sel[k]);
        chk({nm, ".s_cti"}, s_cti, (own < 0) ? '0 : m_cti[k]);
        chk({nm, ".s_bte"}, s_bte, (own < 0) ? '0 : m_bte[k]);
        chk({nm, ".m0_rdat"}, m0_rdat, s_rdat);
        chk({nm, ".m1_rdat"}, m1_rdat, s_rdat);
    endtask

    task automatic chk_bus(input string nm, input int own, input int e_hold);
        logic [1:0] eg;
        eg = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
        chk({nm, ".gnt"}, gnt, eg);
        chk({nm, ".m0_ack"}, m0_ack, (own == 0) && s_ack);
        chk({nm, ".m1_ack"}, m1_ack, (own == 1) && s_ack);
        chk({nm, ".hold"}, dbg_hold, e_hold);
        chk_fields(nm, own);
    endtask

    task automatic model_step();
        int prev;
        bit bnd;
        prev = mo_own;
        bnd  = 1'b0;
        if (prev >= 0) bnd = s_ack && (m_cti[prev] == 3'b000 || m_cti[prev] == 3'b111);
        if (mo_gap) begin
            mo_gap = 1'b0;
            if (m_cyc[mo_tgt])          mo_own = mo_tgt;
            else if (m_cyc[1 - mo_tgt]) mo_own = 1 - mo_tgt;
            else                        mo_own = -1;
        end else if (prev < 0) begin
            mo_own = m_cyc[1] ? 1 : (m_cyc[0] ? 0 : -1);
        end else if (!m_cyc[prev]) begin
            mo_own = m_cyc[1 - prev] ? 1 - prev : -1;
        end else if (prev == 0 && bnd && m_cyc[1]) begin
            mo_own = -1;
            mo_gap = 1'b1;
            mo_tgt = 1;
        end else if (prev == 1 && bnd && m_cyc[0] && mo_hold >= MAX_HOLD - 1) begin
            mo_own = -1;
            mo_gap = 1'b1;
            mo_tgt = 0;
        end
        if (prev == 1 && s_ack && m_cyc[0] && mo_hold < MAX_HOLD) mo_hold++;
        if (mo_own == 0 || (mo_own < 0 && !mo_gap)) mo_hold = 0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk_bus(nm, -1, 0);
        rst     = 1'b1;
        mo_own  = -1;
        mo_gap  = 1'b0;
        mo_tgt  = 0;
        mo_hold = 0;
    endtask

    initial begin
        rst      = 1'b1;
        m_adr[0] = 32'h1000_0040;
        m_adr[1] = 32'h2000_0080;
        m_dat[0] = 16'hA5A5;
        m_dat[1] = 16'h5A5A;
        m_sel[0] = 2'b11;
        m_sel[1] = 2'b01;
        m_we[0]  = 1'b1;
        m_we[1]  = 1'b0;
        m_bte[0] = 2'b00;
        m_bte[1] = 2'b01;
        s_rdat   = 16'hBEEF;
        set_in(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_bus("por", -1, 0);

        // Table: single-master burst, simultaneous request, owner drop, stray ack in IDLE.
        vecs[0] = '{1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, HW'(0)};
        for (int i = 1; i <= 7; i++)
            vecs[i] = '{1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, HW'(0)};
        vecs[8]  = '{1'b1, 1'b0, 3'b111, 3'b000, 1'b1, 2'b01, 1'b1, 1'b0, HW'(0)};
        vecs[9]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, HW'(0)};
        vecs[10] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, HW'(0)};
        vecs[11] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, HW'(0)};
        vecs[12] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b1, 2'b10, 1'b0, 1'b1, HW'(0)};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b10, 1'b0, 1'b0, HW'(1)};
        vecs[14] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, HW'(0)};
        vecs[15] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b01, 1'b0, 1'b0, HW'(0)};
        vecs[16] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'b00, 1'b0, 1'b0, HW'(0)};
        vecs[17] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, HW'(0)};

        do_reset("rst0");
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_in(vecs[i].c0, vecs[i].c1, vecs[i].t0, vecs[i].t1, vecs[i].ack);
            #1;
            chk($sformatf("vec%0d.gnt", i), gnt, vecs[i].e_gnt);
            chk($sformatf("vec%0d.m0_ack", i), m0_ack, vecs[i].e_a0);
            chk($sformatf("vec%0d.m1_ack", i), m1_ack, vecs[i].e_a1);
            chk($sformatf("vec%0d.hold", i), dbg_hold, vecs[i].e_hold);
            chk_fields($sformatf("vec%0d", i), (vecs[i].e_gnt == 2'b01) ? 0 :
                                               ((vecs[i].e_gnt == 2'b10) ? 1 : -1));
        end

        // m1 requests at beat 3 of an m0 burst: m0 finishes, one dead slot, then m1.
        do_reset("rst3");
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'b010, 3'b000, 1'b0);
        #1 chk_bus("t3.idle", -1, 0);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            set_in(1'b1, (b >= 2), (b == 7) ? 3'b111 : 3'b010, 3'b000, 1'b1);
            #1 chk_bus($sformatf("t3.beat%0d", b), 0, 0);
        end
        @(negedge clk);
        set_in(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        #1 chk_bus("t3.dead", -1, 0);
        @(negedge clk);
        #1 chk_bus("t3.m1", 1, 0);

        // Hold guard with MAX_HOLD=4: four m1 acks, then m0 gets one transfer.
        do_reset("rst4");
        @(negedge clk);
        set_in(1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        #1 chk_bus("t4.idle", -1, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
            #1 chk_bus($sformatf("t4.m1ack%0d", k), 1, k);
        end
        @(negedge clk);
        #1 chk_bus("t4.sw", -1, MAX_HOLD);
        @(negedge clk);
        #1 chk_bus("t4.m0", 0, 0);
        @(negedge clk);
        set_in(1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        #1 chk_bus("t4.sw2", -1, 0);
        @(negedge clk);
        #1 chk_bus("t4.m1again", 1, 0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        #1 chk_bus("t4.drop", 1, 0);

        // Asynchronous reset in the middle of a burst beat.
        do_reset("rst5");
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'b010, 3'b000, 1'b0);
        @(negedge clk);
        set_in(1'b1, 1'b0, 3'b010, 3'b000, 1'b1);
        #1 chk_bus("t5.pre", 0, 0);
        #1 rst = 1'b0;
        #1;
        chk("t5.s_cyc", s_cyc, 1'b0);
        chk("t5.s_stb", s_stb, 1'b0);
        chk("t5.m0_ack", m0_ack, 1'b0);
        chk("t5.m1_ack", m1_ack, 1'b0);
        chk("t5.gnt", gnt, 2'b00);
        @(negedge clk);
        set_in(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk_bus($sformatf("t5.idle%0d", i), -1, 0);
        end

        // Random traffic against the model.
        do_reset("rstr");
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int r;
                if ($urandom_range(0, 9) < 2) m_cyc[k] = ~m_cyc[k];
                m_stb[k] = m_cyc[k] & ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 3);
                m_cti[k] = (r == 0) ? 3'b000 : ((r == 3) ? 3'b111 : 3'b010);
                m_adr[k] = $urandom;
                m_dat[k] = DW'($urandom);
                m_sel[k] = (DW/8)'($urandom);
                m_we[k]  = 1'($urandom);
                m_bte[k] = 2'($urandom);
            end
            s_ack  = ($urandom_range(0, 9) < 6);
            s_rdat = DW'($urandom);
            #1 chk_bus("rnd", mo_own, mo_hold);
            @(posedge clk);
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
